// File: rtl/harvos_mpu_pkg.sv
// Shared types for the region-locking MPU: access/privilege enums, the region
// descriptor and the inclusive address-range match helper.
package harvos_mpu_pkg;

  localparam int MPU_AW           = 32;
  localparam int SMPUCTL_LOCK_BIT = 0;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } acc_e;

  typedef enum logic {
    PRIV_U = 1'b0,
    PRIV_S = 1'b1
  } priv_e;

  typedef struct packed {
    logic              valid;
    logic [MPU_AW-1:0] base;
    logic [MPU_AW-1:0] limit;
    logic              r;
    logic              w;
    logic              x;
    logic              user_ok;
    logic              is_ispace;
  } mpu_region_s;

  function automatic logic rgn_match(input mpu_region_s rgn, input logic [MPU_AW-1:0] addr);
    return rgn.valid && (rgn.base <= addr) && (addr <= rgn.limit);
  endfunction

endpackage

// File: rtl/mpu_prio_match.sv
// NREG-way inclusive range compare with lowest-index-wins priority encoding.
module mpu_prio_match
  import harvos_mpu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IDXW = $clog2(NREG)
) (
  input  mpu_region_s       rgn_tbl [NREG],
  input  logic [MPU_AW-1:0] addr,
  output logic              hit,
  output logic [IDXW-1:0]   hit_idx
);

  logic [NREG-1:0] match_s;
  logic            unused_s;

  // Range compare per region, then scan from the top so the lowest index lands last.
  always_comb begin
    match_s  = '0;
    hit_idx  = '0;
    unused_s = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      match_s[i] = rgn_match(rgn_tbl[i], addr);
      unused_s   = unused_s ^ (^{rgn_tbl[i].r, rgn_tbl[i].w, rgn_tbl[i].x,
                                 rgn_tbl[i].user_ok, rgn_tbl[i].is_ispace});
    end
    for (int i = NREG - 1; i >= 0; i--) begin
      hit_idx = match_s[i] ? IDXW'(i) : hit_idx;
    end
    hit = |match_s;
  end

endmodule

// File: rtl/mpu_rgn_lock.sv
// Region MPU with sticky per-region locks, latched global lock, registered
// access check and first-fault capture. Define MPU_FAULT_CNT_EN for the fault counter.
module mpu_rgn_lock
  import harvos_mpu_pkg::*;
#(
  parameter int NREG        = 8,
  parameter int ADDR_W      = 32,
  parameter bit DEF_S_ALLOW = 1'b1,
  parameter int CNT_W       = 8,
  localparam int IDXW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       smpuctl_q,
  input  logic              prog_valid,
  input  logic [IDXW-1:0]   prog_idx,
  input  mpu_region_s       prog_region,
  input  logic              prog_lock,
  output logic              prog_ack,
  output logic              prog_err,
  input  logic              req_valid,
  input  acc_e              acc_type,
  input  priv_e             cur_priv,
  input  logic [ADDR_W-1:0] phys_addr,
  output logic              rsp_valid,
  output logic              allow,
  output logic              hit,
  output logic [IDXW-1:0]   hit_idx,
  output logic              is_ispace_region,
  output logic [NREG-1:0]   rgn_locked,
  output logic              flt_valid,
  output logic [ADDR_W-1:0] flt_addr,
  output acc_e              flt_type,
  output priv_e             flt_priv,
  input  logic              flt_clr,
  output logic [CNT_W-1:0]  flt_cnt
);

  typedef enum logic {
    FLT_EMPTY = 1'b0,
    FLT_HELD  = 1'b1
  } flt_state_e;

  mpu_region_s       rgn_q [NREG];
  mpu_region_s       rgn_d [NREG];
  logic [NREG-1:0]   lock_q, lock_d;
  logic              glock_q, glock_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              allow_q, allow_d;
  logic              hit_q, hit_d;
  logic [IDXW-1:0]   hit_idx_q, hit_idx_d;
  logic              isp_q, isp_d;
  logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
  acc_e              acc_type_q, acc_type_d;
  priv_e             acc_priv_q, acc_priv_d;

  flt_state_e        flt_state_q;
  logic [ADDR_W-1:0] flt_addr_q;
  acc_e              flt_type_q;
  priv_e             flt_priv_q;

  logic              m_hit_s;
  logic [IDXW-1:0]   m_idx_s;
  mpu_region_s       sel_rgn_s;
  logic              perm_s;
  logic              priv_ok_s;
  logic              idx_ok_s;
  logic              cur_lock_s;
  logic              wr_err_s;
  logic              wr_accept_s;
  logic              fault_s;
  logic              unused_s;

  assign unused_s = ^(smpuctl_q & ~(32'd1 << SMPUCTL_LOCK_BIT));

  mpu_prio_match #(
    .NREG (NREG),
    .IDXW (IDXW)
  ) u_match (
    .rgn_tbl (rgn_q),
    .addr    (MPU_AW'(phys_addr)),
    .hit     (m_hit_s),
    .hit_idx (m_idx_s)
  );

  // Programming path: validate the write against locks and range, then stage the table update.
  always_comb begin
    glock_d    = glock_q | smpuctl_q[SMPUCTL_LOCK_BIT];
    idx_ok_s   = ({{(32-IDXW){1'b0}}, prog_idx} < 32'(NREG));
    cur_lock_s = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      cur_lock_s = (prog_idx == IDXW'(i)) ? lock_q[i] : cur_lock_s;
    end
    wr_err_s    = glock_q | (idx_ok_s & cur_lock_s) | ~idx_ok_s |
                  (prog_region.valid & (prog_region.base > prog_region.limit));
    wr_accept_s = prog_valid & ~wr_err_s;
    ack_d       = prog_valid;
    err_d       = prog_valid & wr_err_s;
    lock_d      = lock_q;
    for (int i = 0; i < NREG; i++) begin
      rgn_d[i]  = (wr_accept_s && (prog_idx == IDXW'(i))) ? prog_region : rgn_q[i];
      lock_d[i] = lock_q[i] | (wr_accept_s & prog_lock & (prog_idx == IDXW'(i)));
    end
  end

  // Check path: permission of the winning region, or the miss default.
  always_comb begin
    sel_rgn_s = '0;
    for (int i = 0; i < NREG; i++) begin
      sel_rgn_s = (m_idx_s == IDXW'(i)) ? rgn_q[i] : sel_rgn_s;
    end
    case (acc_type)
      ACC_FETCH: perm_s = sel_rgn_s.x;
      ACC_LOAD:  perm_s = sel_rgn_s.r;
      ACC_STORE: perm_s = sel_rgn_s.w;
      default:   perm_s = 1'b0;
    endcase
    priv_ok_s   = (cur_priv == PRIV_S) | sel_rgn_s.user_ok;
    rsp_valid_d = req_valid;
    acc_addr_d  = phys_addr;
    acc_type_d  = acc_type;
    acc_priv_d  = cur_priv;
    if (!req_valid) begin
      allow_d   = 1'b0;
      hit_d     = 1'b0;
      hit_idx_d = '0;
      isp_d     = 1'b0;
    end else if (m_hit_s) begin
      allow_d   = perm_s & priv_ok_s;
      hit_d     = 1'b1;
      hit_idx_d = m_idx_s;
      isp_d     = sel_rgn_s.is_ispace;
    end else begin
      allow_d   = (cur_priv == PRIV_S) ? DEF_S_ALLOW : 1'b0;
      hit_d     = 1'b0;
      hit_idx_d = '0;
      isp_d     = 1'b0;
    end
  end

  // Table, lock, handshake and check-response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rgn_q[i] <= '0;
      end
      lock_q      <= '0;
      glock_q     <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      allow_q     <= 1'b0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      isp_q       <= 1'b0;
      acc_addr_q  <= '0;
      acc_type_q  <= ACC_FETCH;
      acc_priv_q  <= PRIV_U;
    end else begin
      rgn_q       <= rgn_d;
      lock_q      <= lock_d;
      glock_q     <= glock_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      allow_q     <= allow_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      isp_q       <= isp_d;
      acc_addr_q  <= acc_addr_d;
      acc_type_q  <= acc_type_d;
      acc_priv_q  <= acc_priv_d;
    end
  end

  assign fault_s = rsp_valid_q & ~allow_q;

  // First-fault capture; a clear that coincides with a new fault keeps the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_state_q <= FLT_EMPTY;
      flt_addr_q  <= '0;
      flt_type_q  <= ACC_FETCH;
      flt_priv_q  <= PRIV_U;
    end else begin
      case (flt_state_q)
        FLT_EMPTY: begin
          if (fault_s) begin
            flt_state_q <= FLT_HELD;
            flt_addr_q  <= acc_addr_q;
            flt_type_q  <= acc_type_q;
            flt_priv_q  <= acc_priv_q;
          end else begin
            flt_state_q <= FLT_EMPTY;
          end
        end
        FLT_HELD: begin
          if (fault_s && flt_clr) begin
            flt_state_q <= FLT_HELD;
            flt_addr_q  <= acc_addr_q;
            flt_type_q  <= acc_type_q;
            flt_priv_q  <= acc_priv_q;
          end else if (flt_clr) begin
            flt_state_q <= FLT_EMPTY;
          end else begin
            flt_state_q <= FLT_HELD;
          end
        end
        default: flt_state_q <= FLT_EMPTY;
      endcase
    end
  end

`ifdef MPU_FAULT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating denial counter, independent of the capture state.
  always_comb begin
    if (flt_clr) begin
      cnt_d = fault_s ? CNT_W'(1) : '0;
    end else if (fault_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign flt_cnt = cnt_q;
`else
  assign flt_cnt = '0;
`endif

  assign prog_ack         = ack_q;
  assign prog_err         = err_q;
  assign rsp_valid        = rsp_valid_q;
  assign allow            = allow_q;
  assign hit              = hit_q;
  assign hit_idx          = hit_idx_q;
  assign is_ispace_region = isp_q;
  assign rgn_locked       = lock_q;
  assign flt_valid        = (flt_state_q == FLT_HELD);
  assign flt_addr         = flt_addr_q;
  assign flt_type         = flt_type_q;
  assign flt_priv         = flt_priv_q;

endmodule

// File: tb/tb_mpu_rgn_lock.sv
// Directed bench for mpu_rgn_lock (NREG=6 so an out-of-range index is encodable).
module tb_mpu_rgn_lock;
  import harvos_mpu_pkg::*;

  localparam int NREG = 6;
  localparam int IDXW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       smpuctl_q;
  logic              prog_valid;
  logic [IDXW-1:0]   prog_idx;
  mpu_region_s       prog_region;
  logic              prog_lock;
  logic              prog_ack;
  logic              prog_err;
  logic              req_valid;
  acc_e              acc_type;
  priv_e             cur_priv;
  logic [31:0]       phys_addr;
  logic              rsp_valid;
  logic              allow;
  logic              hit;
  logic [IDXW-1:0]   hit_idx;
  logic              is_ispace_region;
  logic [NREG-1:0]   rgn_locked;
  logic              flt_valid;
  logic [31:0]       flt_addr;
  acc_e              flt_type;
  priv_e             flt_priv;
  logic              flt_clr;
  logic [7:0]        flt_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mpu_rgn_lock #(
    .NREG        (NREG),
    .ADDR_W      (32),
    .DEF_S_ALLOW (1'b1),
    .CNT_W       (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .smpuctl_q        (smpuctl_q),
    .prog_valid       (prog_valid),
    .prog_idx         (prog_idx),
    .prog_region      (prog_region),
    .prog_lock        (prog_lock),
    .prog_ack         (prog_ack),
    .prog_err         (prog_err),
    .req_valid        (req_valid),
    .acc_type         (acc_type),
    .cur_priv         (cur_priv),
    .phys_addr        (phys_addr),
    .rsp_valid        (rsp_valid),
    .allow            (allow),
    .hit              (hit),
    .hit_idx          (hit_idx),
    .is_ispace_region (is_ispace_region),
    .rgn_locked       (rgn_locked),
    .flt_valid        (flt_valid),
    .flt_addr         (flt_addr),
    .flt_type         (flt_type),
    .flt_priv         (flt_priv),
    .flt_clr          (flt_clr),
    .flt_cnt          (flt_cnt)
  );

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef MPU_FAULT_CNT_EN
    return 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  function automatic mpu_region_s mk(input logic v, input logic [31:0] b, input logic [31:0] l,
                                     input logic r, input logic w, input logic x,
                                     input logic u, input logic i);
    mpu_region_s rg;
    rg.valid = v; rg.base = b; rg.limit = l;
    rg.r = r; rg.w = w; rg.x = x; rg.user_ok = u; rg.is_ispace = i;
    return rg;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_prog(input string tag, input logic [IDXW-1:0] idx, input mpu_region_s rg,
                         input logic lk, input logic exp_err);
    @(negedge clk);
    prog_valid = 1'b1; prog_idx = idx; prog_region = rg; prog_lock = lk;
    @(negedge clk);
    prog_valid = 1'b0; prog_lock = 1'b0;
    check({tag, "_ack"}, 64'(prog_ack), 64'd1);
    check({tag, "_err"}, 64'(prog_err), 64'(exp_err));
  endtask

  task automatic do_chk(input string tag, input acc_e at, input priv_e pv, input logic [31:0] a,
                        input logic e_allow, input logic e_hit, input logic [IDXW-1:0] e_idx,
                        input logic e_isp);
    @(negedge clk);
    req_valid = 1'b1; acc_type = at; cur_priv = pv; phys_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_rsp"},   64'(rsp_valid), 64'd1);
    check({tag, "_allow"}, 64'(allow), 64'(e_allow));
    check({tag, "_hit"},   64'(hit), 64'(e_hit));
    check({tag, "_idx"},   64'(hit_idx), 64'(e_idx));
    check({tag, "_isp"},   64'(is_ispace_region), 64'(e_isp));
  endtask

  initial begin
    rst = 1'b1; smpuctl_q = 32'd0; prog_valid = 1'b0; prog_idx = '0; prog_region = '0;
    prog_lock = 1'b0; req_valid = 1'b0; acc_type = ACC_FETCH; cur_priv = PRIV_U;
    phys_addr = 32'd0; flt_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ack",    64'(prog_ack), 64'd0);
    check("rst_rsp",    64'(rsp_valid), 64'd0);
    check("rst_allow",  64'(allow), 64'd0);
    check("rst_locked", 64'(rgn_locked), 64'd0);
    check("rst_flt",    64'(flt_valid), 64'd0);
    check("rst_cnt",    64'(flt_cnt), 64'd0);

    // Region 0: RX, user, I-space.
    do_prog("p_r0", 3'd0, mk(1'b1, 32'h0000_0000, 32'h0000_FFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0);
    do_chk("fetch_u", ACC_FETCH, PRIV_U, 32'h0000_0100, 1'b1, 1'b1, 3'd0, 1'b1);
    @(negedge clk);
    check("idle_rsp",   64'(rsp_valid), 64'd0);
    check("idle_allow", 64'(allow), 64'd0);

    // Overlap: lowest index wins.
    do_prog("p_r1", 3'd1, mk(1'b1, 32'h2000_0000, 32'h2001_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    do_prog("p_r2", 3'd2, mk(1'b1, 32'h2000_0000, 32'h2000_0FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    do_chk("store_s", ACC_STORE, PRIV_S, 32'h2000_0010, 1'b1, 1'b1, 3'd1, 1'b0);

    // Locks.
    do_prog("p_r1_lk", 3'd1, mk(1'b1, 32'h2000_0000, 32'h2001_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0);
    check("locked_r1", 64'(rgn_locked), 64'h02);
    do_prog("p_r1_rej", 3'd1, mk(1'b1, 32'h2000_0000, 32'h2001_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1);
    do_chk("fetch_r1", ACC_FETCH, PRIV_S, 32'h2000_0010, 1'b0, 1'b1, 3'd1, 1'b0);
    @(negedge clk);
    check("f0_valid", 64'(flt_valid), 64'd1);
    check("f0_addr",  64'(flt_addr), 64'h2000_0010);
    check("f0_cnt",   64'(flt_cnt), 64'(exp_cnt(1)));
    flt_clr = 1'b1;
    @(negedge clk);
    flt_clr = 1'b0;
    check("clr_valid", 64'(flt_valid), 64'd0);
    check("clr_cnt",   64'(flt_cnt), 64'd0);
    do_prog("p_r3", 3'd3, mk(1'b1, 32'h3000_0000, 32'h3000_00FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);

    // Boundaries around region 0's limit.
    do_chk("lim_s",   ACC_LOAD, PRIV_S, 32'h0000_FFFF, 1'b1, 1'b1, 3'd0, 1'b1);
    do_chk("lim1_s",  ACC_LOAD, PRIV_S, 32'h0001_0000, 1'b1, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    check("lim1_noflt", 64'(flt_valid), 64'd0);

    // Faults.
    do_prog("p_r4", 3'd4, mk(1'b1, 32'h1000_0000, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    do_chk("f1", ACC_LOAD, PRIV_U, 32'h1000_0000, 1'b0, 1'b1, 3'd4, 1'b0);
    @(negedge clk);
    check("f1_valid", 64'(flt_valid), 64'd1);
    check("f1_addr",  64'(flt_addr), 64'h1000_0000);
    check("f1_type",  64'(flt_type), 64'(ACC_LOAD));
    check("f1_priv",  64'(flt_priv), 64'(PRIV_U));
    check("f1_cnt",   64'(flt_cnt), 64'(exp_cnt(1)));
    do_chk("f2_lim1_u", ACC_LOAD, PRIV_U, 32'h0001_0000, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    check("f2_addr", 64'(flt_addr), 64'h1000_0000);
    check("f2_cnt",  64'(flt_cnt), 64'(exp_cnt(2)));
    @(negedge clk);
    req_valid = 1'b1; acc_type = ACC_STORE; cur_priv = PRIV_U; phys_addr = 32'h2000_0010;
    @(negedge clk);
    req_valid = 1'b0; flt_clr = 1'b1;
    check("f3_allow", 64'(allow), 64'd0);
    @(negedge clk);
    flt_clr = 1'b0;
    check("f3_valid", 64'(flt_valid), 64'd1);
    check("f3_addr",  64'(flt_addr), 64'h2000_0010);
    check("f3_type",  64'(flt_type), 64'(ACC_STORE));
    check("f3_cnt",   64'(flt_cnt), 64'(exp_cnt(1)));

    // Rejected writes.
    do_prog("p_badrng", 3'd5, mk(1'b1, 32'h0000_0010, 32'h0000_000F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1);
    do_prog("p_badidx", 3'd6, mk(1'b1, 32'h4000_0000, 32'h4000_00FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1);

    // Global lock latches after a one-cycle pulse.
    @(negedge clk);
    smpuctl_q = 32'd1;
    @(negedge clk);
    smpuctl_q = 32'd0;
    do_prog("p_glock", 3'd5, mk(1'b1, 32'h4000_0000, 32'h4000_00FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1);

    // Reset clears table, locks, fault and global lock.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_locked", 64'(rgn_locked), 64'd0);
    check("rst2_flt",    64'(flt_valid), 64'd0);
    check("rst2_cnt",    64'(flt_cnt), 64'd0);
    do_chk("rst2_miss", ACC_LOAD, PRIV_S, 32'h0000_0100, 1'b1, 1'b0, 3'd0, 1'b0);
    do_prog("p_after_rst", 3'd1, mk(1'b1, 32'h2000_0000, 32'h2001_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    do_chk("fetch_r1_new", ACC_FETCH, PRIV_S, 32'h2000_0010, 1'b1, 1'b1, 3'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu_rgn_lock.md
Name: mpu_rgn_lock

Overview:
- Parametrised successor to the 8-region MPU.
- Adds per-region sticky lock bits and a latched global lock.
- Programming uses a handshake with an error response.
- The access check is registered (one-cycle latency) with lowest-index priority.
- The first faulting access is captured for the trap handler.
- Sits between the AGU/fetch unit and the bus; the CSR unit programs it.

Parameters:
- NREG, 8, number of regions (2..32)
- ADDR_W, 32, physical address width
- DEF_S_ALLOW, 1, supervisor access allowed on no-region hit (user is always denied on miss)
- CNT_W, 8, fault counter width (used only with MPU_FAULT_CNT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- smpuctl_q  in  32  CSR; bit0 requests global lock
- prog_valid  in  1  program request
- prog_idx  in  IDXW=$clog2(NREG)  region index
- prog_region  in  mpu_region_s  {valid, base, limit, r, w, x, user_ok, is_ispace}
- prog_lock  in  1  set this region's lock together with the write
- prog_ack  out  1  one-cycle completion pulse
- prog_err  out  1  write rejected; valid with prog_ack
- req_valid  in  1  access check request
- acc_type  in  acc_e  fetch/load/store
- cur_priv  in  priv_e  U/S
- phys_addr  in  ADDR_W  access address
- rsp_valid  out  1  check result valid
- allow  out  1  access permitted
- hit  out  1  a region matched
- hit_idx  out  IDXW  matching region
- is_ispace_region  out  1  matched region is I-space
- rgn_locked  out  NREG  per-region lock state
- flt_valid  out  1  fault captured
- flt_addr  out  ADDR_W  captured address
- flt_type  out  acc_e  captured access type
- flt_priv  out  priv_e  captured privilege
- flt_clr  in  1  clear fault capture
- flt_cnt  out  CNT_W  saturating fault count (MPU_FAULT_CNT_EN only)

Behaviour:
- Reset: all regions invalid and zeroed; locks, global lock and all outputs 0.
- Global lock:
  - glock_q is set on any cycle with smpuctl_q[0]=1.
  - Clearing the CSR bit does not unlock; only rst clears it.
- Programming:
  - prog_valid is sampled each cycle; prog_ack pulses the next cycle.
  - prog_err=1 and the write is suppressed if any of these hold: glock_q, rgn_locked[idx], idx>=NREG, or valid && base>limit.
  - An accepted write updates the region next cycle.
  - prog_lock=1 on an accepted write sets rgn_locked[idx]; a rejected write leaves the lock unchanged.
  - Back-to-back requests are legal, one per cycle.
- Check: combinational match, then registered outputs; results appear the cycle after req_valid.
  - Match: valid && base<=addr<=limit, inclusive, unsigned; lowest matching index wins.
  - Permission needed: fetch needs x, load needs r, store needs w.
  - U additionally requires user_ok; S ignores user_ok.
  - Miss: hit=0, hit_idx=0, is_ispace_region=0; allow=DEF_S_ALLOW for S, 0 for U.
  - Same-cycle program and check: the check uses the old table.
  - rsp_valid=0 implies allow, hit, hit_idx and is_ispace_region are driven 0.
- Fault capture FSM, states EMPTY and HELD:
  - EMPTY to HELD: rsp_valid && !allow loads flt_addr, flt_type and flt_priv.
  - In HELD, later faults do not overwrite.
  - flt_clr returns the FSM to EMPTY.
  - flt_clr coinciding with a new fault: the new fault is captured and the state stays HELD.
- Reset mid-program: the pending ack is dropped and the table cleared.

Optional Feature:
- MPU_FAULT_CNT_EN defined: flt_cnt increments on every denied response, independent of HELD state.
  - It saturates at all-ones.
  - flt_clr sets it to 0; flt_clr with a simultaneous fault sets it to 1.
- Undefined: no counter logic; flt_cnt is tied to 0.

Decomposition:
- Package harvos_mpu_pkg holds acc_e, priv_e, mpu_region_s, the SMPUCTL_LOCK_BIT=0 constant and the region-match helper function.
- One sub-module, mpu_prio_match: combinational NREG-way range compare plus priority encoder, outputting hit and hit_idx.

Test Plan:
- Program region 0 as 0x0000_0000..0x0000_FFFF RX/user/ispace, then fetch U at 0x100 -> next cycle allow=1, hit_idx=0, is_ispace_region=1.
- Overlapping regions: region 1 as 0x2000_0000..0x2001_FFFF RW, region 2 as 0x2000_0000..0x2000_0FFF R. Store S at 0x2000_0010 -> hit_idx=1, allow=1.
- Lock checks:
  - prog_lock on region 1; rewrite region 1 as XWR -> prog_err=1, region 1 x stays 0.
  - Write region 3 -> prog_err=0.
- Global lock: pulse smpuctl_q[0] for one cycle and deassert it; any write -> prog_err=1. After rst, writes succeed.
- Faults and counter:
  - Load U at 0x1000_0000 (region not user_ok) -> allow=0, flt_valid=1, flt_addr=0x1000_0000.
  - A second fault leaves flt_addr unchanged; flt_cnt=2.
  - flt_clr in the same cycle as a third fault -> new flt_addr captured, flt_cnt=1.
- Boundaries: access at limit passes, at limit+1 misses (S allowed, U denied); base>limit write -> prog_err=1; prog_idx=NREG -> prog_err=1.
